mult_div_unit: RTL and testbench

Iterative multiply/divide unit in the pipeline's EX stage, feeding the HI/LO register pair. Executes MULT, MULTU, DIV and DIVU as a radix-2 shift-add / restoring-divide engine over WIDTH iterations. Delivers the 2·WIDTH-bit result as hi/lo words plus a one-cycle write strobe. While an operation is in flight it raises `busy` so hazard logic stalls MFHI/MFLO and further mult/div instructions.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_if.sv | 27 ++
 rtl/mdu_sign_fix.sv | 40 ++++
 rtl/mult_div_unit.sv | 133 +++++++++++++
 tb/tb_mult_div_unit.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

    // Operation encodings: bit 1 selects divide, bit 0 selects unsigned.
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter width for a given operand width.
    function automatic int iter_w(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int ITER_W = $clog2(32) + 1;

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// Handshake: start/op/a/b are sampled only while the unit is idle (busy=0);
// start during busy is dropped. hiloWrite is a one-cycle strobe and the only
// qualifier for hiOut/loOut. cancel aborts an operation in flight.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic [WIDTH-1:0] hiOut;
    logic [WIDTH-1:0] loOut;
    logic             hiloWrite;

    modport master (
        output start, op, a, b, cancel,
        input  busy, hiOut, loOut, hiloWrite
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, hiOut, loOut, hiloWrite
    );
endinterface

// File: rtl/mdu_sign_fix.sv
// Converts the magnitude result of the shared datapath into signed hi/lo words.
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] raw,
    input  logic [1:0]         op,
    input  logic               sa,
    input  logic               sb,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               is_signed;

    // Multiply negates the full product; divide negates quotient and remainder separately.
    always_comb begin
        prod      = raw;
        quot      = raw[WIDTH-1:0];
        rem       = raw[2*WIDTH-1:WIDTH];
        is_signed = ~op[0];
        hi        = '0;
        lo        = '0;
        if (op[1]) begin
            lo = (is_signed && (sa ^ sb)) ? -quot : quot;
            hi = (is_signed && sa) ? -rem : rem;
        end else begin
            if (is_signed && (sa ^ sb)) begin
                prod = -raw;
            end
            hi = prod[2*WIDTH-1:WIDTH];
            lo = prod[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU engine feeding the HI/LO register pair.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic   clk,
    input  logic   rst,
    mdu_if.slave   io,
    output state_t dbg_state
);

    localparam int            CW   = iter_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic [1:0]         op_q;
    logic               sa, sb, div_zero;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH:0]   acc, acc_next;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    logic [WIDTH:0]     sum, rem_sh, diff;
    logic               launch, finish;
    logic               in_signed, in_sa, in_sb;
    logic [WIDTH-1:0]   in_abs_a, in_abs_b;

    assign launch    = (state == S_IDLE) && io.start && !io.cancel;
    assign finish    = (state == S_CALC) && !io.cancel && (count == LAST);
    assign in_signed = ~io.op[0];
    assign in_sa     = in_signed & io.a[WIDTH-1];
    assign in_sb     = in_signed & io.b[WIDTH-1];
    assign in_abs_a  = in_sa ? -io.a : io.a;
    assign in_abs_b  = in_sb ? -io.b : io.b;

    assign io.busy      = (state != S_IDLE);
    assign io.hiloWrite = (state == S_DONE) && !io.cancel;
    assign io.hiOut     = hi_q;
    assign io.loOut     = lo_q;
    assign dbg_state    = state;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next-state logic; cancel wins over everything outside IDLE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (launch) state_next = S_CALC;
            S_CALC:  if (io.cancel) state_next = S_IDLE;
                     else if (count == LAST) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // One shift-add or restoring-subtract step on the shared accumulator.
    always_comb begin
        acc_next = acc;
        sum      = '0;
        rem_sh   = '0;
        diff     = '0;
        if (op_q[1]) begin
            rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
            diff   = rem_sh - {1'b0, opnd};
            if (!diff[WIDTH]) acc_next = {1'b0, diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else              acc_next = {1'b0, rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            sum      = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
            acc_next = {1'b0, sum, acc[WIDTH-1:1]};
        end
    end

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .raw (acc_next[2*WIDTH-1:0]),
        .op  (op_q),
        .sa  (sa),
        .sb  (sb),
        .hi  (fix_hi),
        .lo  (fix_lo)
    );

    // Operand latch at launch, then one iteration per CALC cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            div_zero <= 1'b0;
            a_q      <= '0;
            opnd     <= '0;
            acc      <= '0;
            count    <= '0;
        end else if (launch) begin
            op_q     <= io.op;
            sa       <= in_sa;
            sb       <= in_sb;
            div_zero <= io.op[1] && (io.b == '0);
            a_q      <= io.a;
            // Multiply keeps |a| as the addend and shifts |b| through the low half;
            // divide keeps |b| as the divisor and shifts |a| through the low half.
            opnd     <= io.op[1] ? in_abs_b : in_abs_a;
            acc      <= {{(WIDTH+1){1'b0}}, io.op[1] ? in_abs_a : in_abs_b};
            count    <= '0;
        end else if (state == S_CALC) begin
            acc      <= acc_next;
            count    <= count + 1'b1;
        end
    end

    // Result words load on the last iteration and hold until the next completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (finish) begin
            if (div_zero) begin
                hi_q <= a_q;
                lo_q <= '1;
            end else begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a queue-based result scoreboard.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;
    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;

    logic [2*W-1:0] exp_q[$];
    int             t0_q[$];
    logic [2*W-1:0] last_res = '0;

    mdu_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .io        (bus),
        .dbg_state (dbg_state)
    );

    // Clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.hiloWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %h expected no write", {bus.hiOut, bus.loOut});
            end else begin
                logic [2*W-1:0] e;
                int             t;
                e = exp_q.pop_front();
                t = t0_q.pop_front();
                check("result", {bus.hiOut, bus.loOut}, e);
                check("latency", 64'(cyc + 1 - t), 64'd33);
                last_res = e;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) return;
        end
        total++;
        bad++;
        $display("FAIL idle_timeout: got busy=1 expected busy=0 within 100 cycles");
    endtask

    // Launch one operation; push its expected result when exp_valid is set.
    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic exp_valid, input logic [2*W-1:0] exp_res);
        wait_idle();
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (exp_valid) begin
            exp_q.push_back(exp_res);
            t0_q.push_back(cyc + 1);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;

        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.op     = OP_MULT;
        bus.a      = '0;
        bus.b      = '0;
        bus.cancel = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_write", 64'(bus.hiloWrite), 64'd0);
        check("reset_hilo", {bus.hiOut, bus.loOut}, 64'd0);
        check("reset_state", 64'(dbg_state), 64'(S_IDLE));
        rst = 1'b1;
        @(negedge clk);

        // MULT -3 * 5, with busy duration measured.
        launch(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(busy_cnt), 64'd33);

        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
        launch(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
        launch(OP_DIV,   32'hFFFF_FFF9, 32'd2,         1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
        launch(OP_DIV,   32'd7,         32'hFFFF_FFFE, 1'b1, 64'h0000_0001_FFFF_FFFD);
        launch(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000);
        launch(OP_DIVU,  32'd100,       32'd0,         1'b1, 64'h0000_0064_FFFF_FFFF);
        launch(OP_DIV,   32'hFFFF_FFF8, 32'd0,         1'b1, 64'hFFFF_FFF8_FFFF_FFFF);

        // DIVU 100/7 with a start pulse while busy that must be dropped.
        launch(OP_DIVU, 32'd100, 32'd7, 1'b1, 64'h0000_0002_0000_000E);
        repeat (4) @(negedge clk);
        check("calc_state", 64'(dbg_state), 64'(S_CALC));
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;

        // Cancel at cycle 10 of CALC: no write, result words unchanged.
        launch(OP_MULT, 32'd3, 32'd3, 1'b0, '0);
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel_busy", 64'(bus.busy), 64'd0);
        check("cancel_hilo", {bus.hiOut, bus.loOut}, last_res);
        @(negedge clk);
        launch(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);

        // Reset at cycle 20 of CALC clears everything immediately.
        launch(OP_MULTU, 32'd9, 32'd9, 1'b0, '0);
        repeat (19) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset_busy", 64'(bus.busy), 64'd0);
        check("midreset_write", 64'(bus.hiloWrite), 64'd0);
        check("midreset_hilo", {bus.hiOut, bus.loOut}, 64'd0);
        last_res = '0;
        @(negedge clk);
        rst = 1'b1;
        launch(OP_MULTU, 32'd6, 32'd7, 1'b1, 64'h0000_0000_0000_002A);

        wait_idle();
        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
